frame_scheduler: RTL

//  Sequences window_buffer for the MFCC front end. Waits for a full frame, then streams the

---
 rtl/frame_scheduler.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Sequences window_buffer for the MFCC front end. Waits until the buffer holds
// a full frame, streams the FRAME_SIZE samples downstream over valid/ready,
// then pulses wb_start_move_o so the buffer hops by MOVE_SIZE. Repeats while
// enable_i is high, giving the downstream chain back-to-back overlapped frames.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          level; run frames while high
//   wb_idle_i         window_buffer idle
//   wb_valid_i        window_buffer holds a readable frame
//   wb_rd_en_o        read request to window_buffer
//   wb_rd_addr_o      frame-relative sample index 0..FRAME_SIZE-1
//   wb_data_i         read data, valid one cycle after wb_rd_en_o
//   wb_start_move_o   one-cycle pulse: advance window by MOVE_SIZE
//   out_valid_o       sample valid to downstream
//   out_ready_i       downstream accept
//   out_data_o        sample
//   out_first_o       sample 0 of the frame (qualified by out_valid_o)
//   out_last_o        sample FRAME_SIZE-1 of the frame
//   frame_cnt_o       frames fully emitted, wraps at 2**16
//   busy_o            scheduler not idle
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int WIDTH      = 16,
    parameter int FRAME_SIZE = 306,
    parameter int MOVE_SIZE  = 123,
    parameter int MAX_FRAMES = 0,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              wb_idle_i,
    input  logic              wb_valid_i,
    output logic              wb_rd_en_o,
    output logic [ADDR_W-1:0] wb_rd_addr_o,
    input  logic [WIDTH-1:0]  wb_data_i,
    output logic              wb_start_move_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WIDTH-1:0]  out_data_o,
    output logic              out_first_o,
    output logic              out_last_o,
    output logic [15:0]       frame_cnt_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);
    localparam logic [15:0]       MAX_CNT   = 16'(MAX_FRAMES);
    localparam bit                LIMITED   = (MAX_FRAMES != 0);

    // A misconfigured instance (index too narrow, or a hop that is not
    // 1..FRAME_SIZE) never leaves IDLE rather than streaming garbage.
    localparam bit PARAMS_OK = (FRAME_SIZE > 0) && (MOVE_SIZE > 0) &&
                               (MOVE_SIZE <= FRAME_SIZE) &&
                               ((2 ** ADDR_W) >= FRAME_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        STREAM,
        DRAIN,
        MOVE,
        WAIT_BUSY
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_pend_addr;

    logic [WIDTH-1:0]  fifo_data  [2];
    logic              fifo_first [2];
    logic              fifo_last  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              issue;
    logic [1:0]        credit_used;
    logic              last_hs;
    logic              limit_hit;
    logic              stop_req;

    assign pop = (count != 2'd0) && out_ready_i;

    // Credit = reads in flight + entries held, taken after this cycle's pop so a
    // full pipe with a draining consumer still sustains one read per cycle.
    assign credit_used = count + {1'b0, rd_pend} - {1'b0, pop};
    assign issue       = (state == STREAM) && (credit_used < 2'd2);

    assign last_hs   = (state == DRAIN) && pop && out_last_o;
    assign limit_hit = LIMITED && (frame_cnt_o >= MAX_CNT);
    assign stop_req  = !enable_i || limit_hit;

    assign wb_rd_en_o      = issue;
    assign wb_rd_addr_o    = rd_addr;
    assign wb_start_move_o = (state == MOVE);
    assign busy_o          = (state != IDLE);
    assign out_valid_o     = (count != 2'd0);
    assign out_data_o      = fifo_data[rd_ptr];
    assign out_first_o     = fifo_first[rd_ptr];
    assign out_last_o      = fifo_last[rd_ptr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A frame that has started always runs through MOVE;
    // enable_i and the frame limit are only honoured between frames.
    // WAIT_BUSY waits for the buffer to drop idle so the idle level left over
    // from before the move is not taken as the refill being complete.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable_i && !limit_hit && PARAMS_OK) begin
                    state_next = WAIT_FILL;
                end
            end
            WAIT_FILL: begin
                if (stop_req) begin
                    state_next = IDLE;
                end else if (wb_idle_i && wb_valid_i) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (issue && (rd_addr == LAST_ADDR)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_next = MOVE;
                end
            end
            MOVE: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!wb_idle_i) begin
                    state_next = stop_req ? IDLE : WAIT_FILL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read index and in-flight tag. The index of each read travels with it so
    // the first/last flags are tied to the data rather than a separate counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr      <= '0;
            rd_pend      <= 1'b0;
            rd_pend_addr <= '0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                rd_pend_addr <= rd_addr;
            end
            if ((state == WAIT_FILL) && (state_next == STREAM)) begin
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
            end
        end
    end

    // Two-entry output FIFO. The credit rule keeps occupancy plus in-flight
    // reads at most two, so a push never lands on a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_first[i] <= 1'b0;
                fifo_last[i]  <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (rd_pend) begin
                fifo_data[wr_ptr]  <= wb_data_i;
                fifo_first[wr_ptr] <= (rd_pend_addr == '0);
                fifo_last[wr_ptr]  <= (rd_pend_addr == LAST_ADDR);
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

    // Frame counter steps on the handshake of the last sample, the same cycle
    // the FSM leaves DRAIN. Only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_o <= 16'd0;
        end else if (last_hs) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

endmodule
